serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
Bit-serial WIDTH-bit subtractor computing D = A - B, one bit per clock, LSB first, through a single full-subtractor cell and a registered borrow. It is the inverse-operation counterpart of the team's combinational full-adder cell. A start/busy/done handshake lets a testbench or controller launch operations and collect results. Intended as the sequential arithmetic block in the tutorial set.

Parameters:
WIDTH, 8, operand and result width in bits (>= 2).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  launch request; sampled in IDLE or DONE
A  input  WIDTH  minuend; captured on accepted start
B  input  WIDTH  subtrahend; captured on accepted start
busy  output  1  high while bits are being processed
done  output  1  one-cycle pulse; D/Bout valid from this cycle
D  output  WIDTH  difference A - B mod 2^WIDTH; held until next completion
Bout  output  1  final borrow (1 when A < B unsigned)

Behaviour:
- Reset (rst_n low, any time, asynchronous): state=IDLE, busy=0, done=0, D=0, Bout=0; shift registers, borrow flop and bit counter cleared. An operation in flight is abandoned; no done is produced.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: start=1 at an edge -> load a_sr=A, b_sr=B, br=0, cnt=0; go to SHIFT.
  - SHIFT: each edge: di = a0^b0^br; br <= (~a0&b0) | (~(a0^b0)&br); shift a_sr, b_sr right by 1; shift di into the result register from the MSB end; cnt <= cnt+1. When cnt==WIDTH-1: D <= final result, Bout <= final borrow, go to DONE.
  - DONE: lasts exactly one cycle. start=1 -> same load as IDLE, go to SHIFT (back-to-back). Otherwise go to IDLE.
- busy = (state==SHIFT); done = (state==DONE). Both are decoded from registered state, so they are glitch-free.
- Latency: start accepted at edge 0; done is high during the cycle after edge WIDTH. Throughput is one operation per WIDTH+1 cycles.
- start is ignored while in SHIFT. A and B are don't-care except at the accepting edge.
- D and Bout change only at the completion edge and hold stable during a following operation.
- Arithmetic is modulo 2^WIDTH. Bout equals the borrow out of bit WIDTH-1.
- cnt width = $clog2(WIDTH). The WIDTH-1 compare must not wrap.

Optional Feature:
Macro SERIAL_SUB_OVERFLOW_EN.
- Defined: adds an output port V (1 bit), two's-complement overflow = (A[W-1]^B[W-1]) & (A[W-1]^D[W-1]) of the completed operation. V is registered alongside D, reset to 0, and held identically to D.
- Undefined: no V port and no related logic.

Decomposition:
- Package serial_sub_pkg: state enum typedef (IDLE, SHIFT, DONE) and a default-width constant SERIAL_SUB_WIDTH_DEFAULT=8.
- Sub-module full_subtractor: combinational one-bit cell with ports (D, Bo, A, B, Bi), instanced once inside serial_subtractor.

Test Plan:
- WIDTH=8, A=0x35, B=0x12, start pulse -> busy for 8 cycles; done in the cycle after edge 8; D=0x23, Bout=0.
- A=0x00, B=0x01 -> D=0xFF, Bout=1. With SERIAL_SUB_OVERFLOW_EN: A=0x80, B=0x01 -> D=0x7F, Bout=0, V=1.
- start held high with new A/B during SHIFT -> ignored; result matches the first operands; D holds the old value until completion.
- start asserted in the DONE cycle with A=0x10, B=0x20 -> no IDLE gap; second done 9 cycles later; D=0xF0, Bout=1.
- rst_n low at cycle 4 of an operation -> busy, done, D and Bout are 0 immediately; no done pulse afterwards; a fresh start then completes correctly.
- Exhaustive sweep with WIDTH=4 (256 A/B pairs, back-to-back) -> every D and Bout matches a reference {Bout,D} = {1'b0,A} - {1'b0,B}.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: FSM state type and default operand width shared by the serial subtractor files
package serial_sub_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    localparam int SERIAL_SUB_WIDTH_DEFAULT = 8;
endpackage

// File: rtl/full_subtractor.sv
// full_subtractor: one-bit combinational cell; A,B,Bi in -> difference D and borrow out Bo
module full_subtractor (
    output logic D,
    output logic Bo,
    input  logic A,
    input  logic B,
    input  logic Bi
);
    assign D  = A ^ B ^ Bi;
    assign Bo = (~A & B) | (~(A ^ B) & Bi);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: LSB-first bit-serial D=A-B; in clk,rst_n,start,A,B; out busy,done,D,Bout (+V when SERIAL_SUB_OVERFLOW_EN)
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = SERIAL_SUB_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Bout
`ifdef SERIAL_SUB_OVERFLOW_EN
    ,
    output logic             V
`endif
);
    localparam int CW = $clog2(WIDTH);
    state_t state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, d_q, d_d, r_n;
    logic [WIDTH-2:0] r_q, r_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic br_q, br_d, bout_q, bout_d, di, bo, load, last;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic v_q, v_d;
    assign V = v_q;
`endif
    full_subtractor u_cell (.D(di), .Bo(bo), .A(a_q[0]), .B(b_q[0]), .Bi(br_q));
    assign load = start && (state_q != SHIFT);
    assign last = cnt_q == CW'(WIDTH - 1);
    assign r_n  = {di, r_q};
    assign busy = state_q == SHIFT;
    assign done = state_q == DONE;
    assign D    = d_q;
    assign Bout = bout_q;
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        d_d     = d_q;
        bout_d  = bout_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
        v_d     = v_q;
`endif
        if (load) begin
            a_d     = A;
            b_d     = B;
            br_d    = 1'b0;
            cnt_d   = '0;
            state_d = SHIFT;
        end else if (state_q == SHIFT) begin
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            r_d   = r_n[WIDTH-1:1];
            br_d  = bo;
            cnt_d = cnt_q + CW'(1);
            if (last) begin
                d_d     = r_n;
                bout_d  = bo;
                state_d = DONE;
`ifdef SERIAL_SUB_OVERFLOW_EN
                v_d     = (a_q[0] ^ b_q[0]) & (a_q[0] ^ di);
`endif
            end
        end else begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            d_q     <= '0;
            bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
            v_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            d_q     <= d_d;
            bout_q  <= bout_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
            v_q     <= v_d;
`endif
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: table + scoreboard bench for serial_subtractor at WIDTH=8 and an exhaustive WIDTH=4 sweep
module tb_serial_subtractor;
    typedef struct {logic [7:0] d; logic bo; logic v;} exp8_t;
    typedef struct {logic [3:0] d; logic bo; logic v;} exp4_t;
    typedef struct {logic [7:0] a; logic [7:0] b; logic [7:0] d; logic bo; logic v;} vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0, start4 = 1'b0;
    logic [7:0] a_in = '0, b_in = '0, d;
    logic [3:0] a4 = '0, b4 = '0, d4;
    logic busy, done, bout, busy4, done4, bout4;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic v, v4;
`endif
    int errs = 0, checks = 0, dones8 = 0, dones4 = 0;
    exp8_t q8[$];
    exp4_t q4[$];
    exp8_t e8;
    exp4_t e4;
    vec_t tv[8];

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .A(a_in), .B(b_in),
        .busy(busy), .done(done), .D(d), .Bout(bout)
`ifdef SERIAL_SUB_OVERFLOW_EN
        , .V(v)
`endif
    );

    serial_subtractor #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .A(a4), .B(b4),
        .busy(busy4), .done(done4), .D(d4), .Bout(bout4)
`ifdef SERIAL_SUB_OVERFLOW_EN
        , .V(v4)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    function automatic exp8_t model8(input logic [7:0] x, input logic [7:0] y);
        exp8_t e;
        logic [8:0] r;
        r = {1'b0, x} - {1'b0, y};
        e.d = r[7:0];
        e.bo = r[8];
        e.v = (x[7] ^ y[7]) & (x[7] ^ r[7]);
        return e;
    endfunction

    function automatic exp4_t model4(input logic [3:0] x, input logic [3:0] y);
        exp4_t e;
        logic [4:0] r;
        r = {1'b0, x} - {1'b0, y};
        e.d = r[3:0];
        e.bo = r[4];
        e.v = (x[3] ^ y[3]) & (x[3] ^ r[3]);
        return e;
    endfunction

    always @(negedge clk) begin
        if (done) begin
            dones8++;
            if (q8.size() == 0) begin
                checks++;
                errs++;
                $display("FAIL spurious_done8: done=1 with nothing pending, required done=0");
            end else begin
                e8 = q8.pop_front();
                chk("sb_d8", 32'(d), 32'(e8.d));
                chk("sb_bout8", 32'(bout), 32'(e8.bo));
`ifdef SERIAL_SUB_OVERFLOW_EN
                chk("sb_v8", 32'(v), 32'(e8.v));
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (done4) begin
            dones4++;
            if (q4.size() == 0) begin
                checks++;
                errs++;
                $display("FAIL spurious_done4: done=1 with nothing pending, required done=0");
            end else begin
                e4 = q4.pop_front();
                chk("sb_d4", 32'(d4), 32'(e4.d));
                chk("sb_bout4", 32'(bout4), 32'(e4.bo));
`ifdef SERIAL_SUB_OVERFLOW_EN
                chk("sb_v4", 32'(v4), 32'(e4.v));
`endif
            end
        end
    end

    task automatic launch8(input logic [7:0] x, input logic [7:0] y, input exp8_t e);
        start = 1'b1;
        a_in = x;
        b_in = y;
        q8.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done8(output int n, output int bc);
        n = 0;
        bc = 0;
        while (!done && n < 30) begin
            if (busy) bc++;
            @(negedge clk);
            n++;
        end
        chk("done8_seen", 32'(done), 32'd1);
    endtask

    task automatic launch4(input logic [3:0] x, input logic [3:0] y);
        start4 = 1'b1;
        a4 = x;
        b4 = y;
        q4.push_back(model4(x, y));
        @(negedge clk);
        start4 = 1'b0;
    endtask

    task automatic wait_done4();
        int n;
        n = 0;
        while (!done4 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("done4_seen", 32'(done4), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, bc, base;
        logic [7:0] p;
        tv[0] = '{8'h35, 8'h12, 8'h23, 1'b0, 1'b0};
        tv[1] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
        tv[2] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
        tv[3] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};
        tv[4] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
        tv[5] = '{8'h7F, 8'h80, 8'hFF, 1'b1, 1'b1};
        tv[6] = '{8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0};
        tv[7] = '{8'h12, 8'h35, 8'hDD, 1'b1, 1'b0};
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_d", 32'(d), 32'd0);
        chk("rst_bout", 32'(bout), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            launch8(tv[i].a, tv[i].b, '{tv[i].d, tv[i].bo, tv[i].v});
            wait_done8(n, bc);
            chk("latency8", 32'(n), 32'd8);
            chk("busy_cycles8", 32'(bc), 32'd8);
            @(negedge clk);
            chk("idle_hold_d", 32'(d), 32'(tv[i].d));
            chk("idle_done_low", 32'(done), 32'd0);
        end
        launch8(8'h40, 8'h01, model8(8'h40, 8'h01));
        start = 1'b1;
        a_in = 8'h00;
        b_in = 8'hFF;
        for (int k = 0; k < 5; k++) begin
            chk("shift_hold_d", 32'(d), 32'hDD);
            chk("shift_busy", 32'(busy), 32'd1);
            @(negedge clk);
        end
        start = 1'b0;
        wait_done8(n, bc);
        chk("ignored_start_d", 32'(d), 32'h3F);
        launch8(8'h10, 8'h20, model8(8'h10, 8'h20));
        chk("b2b_busy", 32'(busy), 32'd1);
        wait_done8(n, bc);
        chk("b2b_latency", 32'(n), 32'd8);
        chk("b2b_d", 32'(d), 32'hF0);
        chk("b2b_bout", 32'(bout), 32'd1);
        @(negedge clk);
        launch8(8'h55, 8'h22, model8(8'h55, 8'h22));
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_d", 32'(d), 32'd0);
        chk("midrst_bout", 32'(bout), 32'd0);
        q8.delete();
        base = dones8;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("no_done_after_rst", 32'(dones8 - base), 32'd0);
        launch8(8'hA0, 8'h0B, model8(8'hA0, 8'h0B));
        wait_done8(n, bc);
        chk("post_rst_d", 32'(d), 32'h95);
        @(negedge clk);
        base = dones4;
        q4.delete();
        for (int i = 0; i < 256; i++) begin
            p = 8'(i);
            if (i > 0) wait_done4();
            launch4(p[7:4], p[3:0]);
        end
        wait_done4();
        @(negedge clk);
        chk("sweep4_count", 32'(dones4 - base), 32'd256);
        chk("q8_drained", 32'(q8.size()), 32'd0);
        chk("q4_drained", 32'(q4.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
